// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: slice sizing and the parameter
// legality rule checked when the block elaborates.
package pipelined_adder_pkg;

   function automatic int stage_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit params_legal(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && (stages <= width) &&
             (width % stages == 0);
   endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered slice of the pipelined adder. It adds slice IDX of the
// operands with the incoming carry and passes the rest of the payload on.
module adder_stage
   import pipelined_adder_pkg::*;
#(
   parameter int  WIDTH  = 8,
   parameter int  STAGES = 2,
   parameter int  IDX    = 0,
   parameter type payload_t = logic
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     load_i,
   input  logic     up_valid_i,
   input  payload_t up_i,
   output logic     valid_o,
   output payload_t data_o
);

   localparam int W  = stage_width(WIDTH, STAGES);
   localparam int LO = IDX * W;

   logic [W:0] slice_full;
   payload_t   data_d;
   payload_t   data_q;
   logic       valid_q;
   logic       unused_up_ovf;

   assign unused_up_ovf = up_i.ovf;

   // Carry into the slice MSB is recovered as a ^ bx ^ sum at that bit, so the
   // overflow flag falls out without a second adder.
   always_comb begin
      slice_full = {1'b0, up_i.a[LO +: W]} + {1'b0, up_i.bx[LO +: W]}
                 + {{W{1'b0}}, up_i.carry};
      data_d = up_i;
      data_d.sum[LO +: W] = slice_full[W-1:0];
      data_d.carry = slice_full[W];
      data_d.ovf = up_i.a[LO+W-1] ^ up_i.bx[LO+W-1] ^ slice_full[W-1] ^ slice_full[W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= up_valid_i;
         if (up_valid_i) begin
            data_q <= data_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry-in, STAGES carry-chained slices and
// valid/ready flow control on both sides.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] bx;
   } payload_t;

   if (!params_legal(WIDTH, STAGES)) begin : g_illegal
      $error("pipelined_adder: WIDTH=%0d STAGES=%0d is not a legal split", WIDTH, STAGES);
   end

   payload_t          pipe [STAGES+1];
   logic [STAGES:0]   vchain;
   logic [STAGES-1:0] stage_load;
   logic              unused_tail;

   assign vchain[0] = in_valid;
   assign pipe[0]   = '{sum: '0, carry: c_in ^ sub, ovf: 1'b0, a: a, bx: sub ? ~b : b};

   // A stage may load whenever any stage from it to the output is empty, or
   // the output is draining: bubbles collapse without a ripple through ready.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign stage_load[k] = out_ready || !(&vchain[STAGES:k+1]);

      adder_stage #(
         .WIDTH    (WIDTH),
         .STAGES   (STAGES),
         .IDX      (k),
         .payload_t(payload_t)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .load_i    (stage_load[k]),
         .up_valid_i(vchain[k]),
         .up_i      (pipe[k]),
         .valid_o   (vchain[k+1]),
         .data_o    (pipe[k+1])
      );
   end

   assign in_ready    = stage_load[0];
   assign out_valid   = vchain[STAGES];
   assign sum         = pipe[STAGES].sum;
   assign c_out       = pipe[STAGES].carry;
   assign ovf         = pipe[STAGES].ovf;
   assign unused_tail = ^{pipe[STAGES].a, pipe[STAGES].bx};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder in three configurations
// (8/2, 16/4, 8/1) sharing one input stream, with per-instance scoreboards.
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        c_in;
   logic        sub;
   logic        out_ready;
   logic [15:0] a_in;
   logic [15:0] b_in;

   logic        m_in_ready, m_out_valid, m_c_out, m_ovf;
   logic [7:0]  m_sum;
   logic        w_in_ready, w_out_valid, w_c_out, w_ovf;
   logic [15:0] w_sum;
   logic        r_in_ready, r_out_valid, r_c_out, r_ovf;
   logic [7:0]  r_sum;

   int checks = 0;
   int errors = 0;

   logic [17:0] q_m[$];
   logic [17:0] q_w[$];
   logic [17:0] q_r[$];
   logic [17:0] e_m, e_w, e_r;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
      .a(a_in[7:0]), .b(b_in[7:0]), .c_in(c_in), .sub(sub),
      .out_valid(m_out_valid), .out_ready(out_ready),
      .sum(m_sum), .c_out(m_c_out), .ovf(m_ovf)
   );

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut_w16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
      .a(a_in), .b(b_in), .c_in(c_in), .sub(sub),
      .out_valid(w_out_valid), .out_ready(out_ready),
      .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf)
   );

   pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
      .a(a_in[7:0]), .b(b_in[7:0]), .c_in(c_in), .sub(sub),
      .out_valid(r_out_valid), .out_ready(out_ready),
      .sum(r_sum), .c_out(r_c_out), .ovf(r_ovf)
   );

   // Reference: {ovf, c_out, sum zero-extended to 16 bits}
   function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic s);
      logic [15:0] mask, am, bx, sm;
      logic [16:0] full;
      logic        co, ov;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      am   = a & mask;
      bx   = (s ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bx} + {16'd0, ci ^ s};
      sm   = full[15:0] & mask;
      co   = full[w];
      ov   = (am[w-1] == bx[w-1]) && (sm[w-1] != am[w-1]);
      return {ov, co, sm};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q_m.delete();
      end else begin
         if (m_out_valid && out_ready) begin
            checks++;
            if (q_m.size() == 0) begin
               errors++;
               $display("FAIL sb_8x2: unexpected result sum=%0d with no beat outstanding", m_sum);
            end else begin
               e_m = q_m.pop_front();
               if ({m_ovf, m_c_out, 8'h00, m_sum} !== e_m) begin
                  errors++;
                  $display("FAIL sb_8x2: got ovf/cout/sum=%h want %h", {m_ovf, m_c_out, 8'h00, m_sum}, e_m);
               end
            end
         end
         if (in_valid && m_in_ready) q_m.push_back(ref_add(8, a_in, b_in, c_in, sub));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q_w.delete();
      end else begin
         if (w_out_valid && out_ready) begin
            checks++;
            if (q_w.size() == 0) begin
               errors++;
               $display("FAIL sb_16x4: unexpected result sum=%0d with no beat outstanding", w_sum);
            end else begin
               e_w = q_w.pop_front();
               if ({w_ovf, w_c_out, w_sum} !== e_w) begin
                  errors++;
                  $display("FAIL sb_16x4: got ovf/cout/sum=%h want %h", {w_ovf, w_c_out, w_sum}, e_w);
               end
            end
         end
         if (in_valid && w_in_ready) q_w.push_back(ref_add(16, a_in, b_in, c_in, sub));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q_r.delete();
      end else begin
         if (r_out_valid && out_ready) begin
            checks++;
            if (q_r.size() == 0) begin
               errors++;
               $display("FAIL sb_8x1: unexpected result sum=%0d with no beat outstanding", r_sum);
            end else begin
               e_r = q_r.pop_front();
               if ({r_ovf, r_c_out, 8'h00, r_sum} !== e_r) begin
                  errors++;
                  $display("FAIL sb_8x1: got ovf/cout/sum=%h want %h", {r_ovf, r_c_out, 8'h00, r_sum}, e_r);
               end
            end
         end
         if (in_valid && r_in_ready) q_r.push_back(ref_add(8, a_in, b_in, c_in, sub));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0; c_in = 1'b0; sub = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
      checks++; if (m_sum !== 8'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", m_sum); end
      checks++; if (m_c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b want 0", m_c_out); end
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", m_ovf); end
      checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
      checks++; if (w_out_valid !== 1'b0 || r_out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_other_valid: got %b%b want 00", w_out_valid, r_out_valid);
      end
      checks++; if (w_sum !== 16'd0) begin errors++; $display("FAIL reset_w16_sum: got %0d want 0", w_sum); end
   endtask

   task automatic test_basic();
      in_valid = 1'b1; a_in = 16'd1; b_in = 16'd2; c_in = 1'b1; sub = 1'b0;
      #1;
      checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", m_in_ready); end
      tick();
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         checks++; if (m_out_valid !== (cyc == 1)) begin
            errors++; $display("FAIL basic_latency_8x2 cyc%0d: got %b want %b", cyc, m_out_valid, cyc == 1);
         end
         checks++; if (r_out_valid !== (cyc == 0)) begin
            errors++; $display("FAIL basic_latency_8x1 cyc%0d: got %b want %b", cyc, r_out_valid, cyc == 0);
         end
         checks++; if (w_out_valid !== (cyc == 3)) begin
            errors++; $display("FAIL basic_latency_16x4 cyc%0d: got %b want %b", cyc, w_out_valid, cyc == 3);
         end
         if (cyc == 1) begin
            checks++; if ({m_ovf, m_c_out, m_sum} !== {1'b0, 1'b0, 8'd4}) begin
               errors++; $display("FAIL basic_result: got sum=%0d c_out=%b ovf=%b want 4/0/0", m_sum, m_c_out, m_ovf);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int ta[3] = '{10, 55, 200};
      int tb[3] = '{20, 66, 100};
      int tc[3] = '{0, 1, 0};
      int es[3] = '{30, 122, 44};
      int ec[3] = '{0, 0, 1};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            in_valid = 1'b1; a_in = 16'(ta[i]); b_in = 16'(tb[i]); c_in = 1'(tc[i]); sub = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         checks++; if (m_out_valid !== (i >= 1 && i <= 3)) begin
            errors++; $display("FAIL b2b_valid i%0d: got %b want %b", i, m_out_valid, i >= 1 && i <= 3);
         end
         if (i >= 1 && i <= 3) begin
            checks++; if (m_sum !== 8'(es[i-1]) || m_c_out !== 1'(ec[i-1])) begin
               errors++; $display("FAIL b2b_result beat%0d: got sum=%0d c_out=%b want %0d/%0d", i-1, m_sum, m_c_out, es[i-1], ec[i-1]);
            end
         end
      end
   endtask

   task automatic test_subtract();
      int ta[2] = '{10, 100};
      int tb[2] = '{20, 100};
      int ts[2] = '{1, 0};
      int es[2] = '{246, 200};
      int eo[2] = '{0, 1};
      for (int i = 0; i < 4; i++) begin
         if (i < 2) begin
            in_valid = 1'b1; a_in = 16'(ta[i]); b_in = 16'(tb[i]); c_in = 1'b0; sub = 1'(ts[i]);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         checks++; if (m_out_valid !== (i >= 1 && i <= 2)) begin
            errors++; $display("FAIL sub_valid i%0d: got %b want %b", i, m_out_valid, i >= 1 && i <= 2);
         end
         if (i >= 1 && i <= 2) begin
            checks++; if (m_sum !== 8'(es[i-1]) || m_c_out !== 1'b0 || m_ovf !== 1'(eo[i-1])) begin
               errors++; $display("FAIL sub_result beat%0d: got sum=%0d c_out=%b ovf=%b want %0d/0/%0d",
                                  i-1, m_sum, m_c_out, m_ovf, es[i-1], eo[i-1]);
            end
         end
      end
      sub = 1'b0;
   endtask

   task automatic test_backpressure();
      int nb = 0;
      int exp_sum[10] = '{0, 0, 2, 2, 2, 2, 4, 6, 8, 0};
      for (int cyc = 0; cyc < 10; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (nb < 4);
         a_in = 16'(nb + 1); b_in = 16'(nb + 1); c_in = 1'b0; sub = 1'b0;
         #1;
         checks++; if (m_in_ready !== (cyc < 2 || cyc >= 5)) begin
            errors++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, m_in_ready, cyc < 2 || cyc >= 5);
         end
         checks++; if (m_out_valid !== (cyc >= 2 && cyc <= 8)) begin
            errors++; $display("FAIL bp_out_valid cyc%0d: got %b want %b", cyc, m_out_valid, cyc >= 2 && cyc <= 8);
         end
         if (cyc >= 2 && cyc <= 8) begin
            checks++; if (m_sum !== 8'(exp_sum[cyc])) begin
               errors++; $display("FAIL bp_sum cyc%0d: got %0d want %0d", cyc, m_sum, exp_sum[cyc]);
            end
         end
         if (in_valid && m_in_ready) nb++;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (nb != 4) begin errors++; $display("FAIL bp_accepted: got %0d beats want 4", nb); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      in_valid = 1'b1; a_in = 16'd5; b_in = 16'd6; c_in = 1'b0; sub = 1'b0;
      tick();
      a_in = 16'd9; b_in = 16'd9;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      checks++; if ({m_out_valid, w_out_valid, r_out_valid} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_valid: got %b%b%b want 000", m_out_valid, w_out_valid, r_out_valid);
      end
      checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", m_in_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if ({m_out_valid, w_out_valid, r_out_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_stale i%0d: got %b%b%b want 000", i, m_out_valid, w_out_valid, r_out_valid);
         end
      end
      in_valid = 1'b1; a_in = 16'd7; b_in = 16'd8;
      tick();
      in_valid = 1'b0;
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lat0: got %b want 0", m_out_valid); end
      tick();
      checks++; if (m_out_valid !== 1'b1 || m_sum !== 8'd15) begin
         errors++; $display("FAIL rst_mid_lat1: got valid=%b sum=%0d want 1/15", m_out_valid, m_sum);
      end
      tick();
      checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lat2: got %b want 0", m_out_valid); end
   endtask

   task automatic test_random();
      int accepted = 0;
      int cyc = 0;
      while (accepted < 1000 && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a_in      = 16'($urandom);
         b_in      = 16'($urandom);
         c_in      = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && m_in_ready) accepted++;
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
      checks++; if (accepted != 1000) begin errors++; $display("FAIL rand_budget: got %0d beats want 1000", accepted); end
      checks++; if (q_m.size() != 0 || q_w.size() != 0 || q_r.size() != 0) begin
         errors++; $display("FAIL rand_drain: got outstanding %0d/%0d/%0d want 0/0/0", q_m.size(), q_w.size(), q_r.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_subtract();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the team's 8-bit combinational ripple adder. It adds or subtracts two WIDTH-bit operands with carry/borrow-in, split into STAGES equal carry-chained slices, one slice per clock. Valid/ready handshakes on both sides give it backpressure, so it can sit between streaming producers and consumers in the datapath. It sustains one result per cycle.

## Interface
- WIDTH, 8: operand and result width. Must be ≥ 2 and divisible by STAGES.
- STAGES, 2: number of pipeline stages. Each stage computes W = WIDTH/STAGES result bits. Legal range is 1..WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A (unsigned / two's complement).
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow).
- ovf  output  1  signed overflow.

## Operation
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Operand conditioning at capture:
  - bx = sub ? ~b : b
  - cx = c_in ^ sub
  - Add computes a+b+c_in. Subtract computes a−b−c_in.
- Stage k (0..STAGES−1) holds:
  - a valid bit
  - result slice [k*W +: W] for all slices already computed
  - carry into slice k+1
  - the uncomputed upper slices of a and bx
- Stage k computes {carry, slice k} = a_k + bx_k + carry_in. Stage 0 uses cx as carry_in.
- The last stage drives sum, c_out (carry out of the top slice) and ovf.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. It is computed inside the top slice.
- Flow control is per stage, with bubbles collapsing:
  - Stage k loads from stage k−1 (or from the input for k = 0) when stage k is empty or is advancing this cycle.
  - The last stage advances on out_ready.
  - in_ready = !valid_0 || advance_0. This is a combinational path from out_ready back through the valid chain; it is accepted.
- Result fields are only meaningful while out_valid = 1. They hold their value while out_valid && !out_ready.

## Timing
- Latency is STAGES cycles from input transfer to out_valid, with no stall.
  - STAGES = 1 gives a registered adder with 1-cycle latency.
- Throughput is 1 beat/cycle while out_ready stays high.
- Simultaneous events:
  - A full pipe with out_ready = 1 accepts a new beat in the same cycle that it emits one.
  - When the last stage stalls, upstream stages fill any bubbles before in_ready drops.
- Reset:
  - The rst cycle clears all valid bits.
  - Reset values: out_valid = 0, sum = 0, c_out = 0, ovf = 0. in_ready = 1 in the cycle after reset.
  - A reset mid-operation discards every in-flight beat. No result from before reset may appear afterwards.
- Wrap-around: results wrap modulo 2^WIDTH. The carry is reported only on c_out.

## Structure
- Package pipelined_adder_pkg holds:
  - the function stage_width(WIDTH, STAGES)
  - the parametrised stage-payload struct (partial sum, carry, remaining a/bx)
  - the legality check, which the block calls from an elaboration-time assertion
- Sub-module adder_stage holds one registered W-bit slice with its valid bit and load/advance logic. The top level generates STAGES instances and the operand conditioning.

## Test plan
All scenarios use WIDTH=8, STAGES=2 and out_ready=1 unless stated otherwise.
- a=1, b=2, c_in=1, sub=0 -> sum=4, c_out=0, ovf=0, out_valid exactly 2 cycles after the transfer.
- Back-to-back beats (10+20+0, 55+66+1, 200+100+0) -> sums 30, 122, 44 on consecutive cycles. The third beat has c_out=1.
- Subtract a=10, b=20, c_in=0, sub=1 -> sum=246, c_out=0, ovf=0. Then a=100, b=100, add -> sum=200, ovf=1.
- Hold out_ready=0 for 5 cycles while offering 4 beats:
  - in_ready drops after 2 beats are held, with no loss or duplication.
  - On release, results emerge in order at 1 per cycle.
  - sum stays stable during the stall.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle. No stale results appear afterwards, and the next beat shows normal 2-cycle latency.
- Rerun the first three scenarios with WIDTH=16, STAGES=4, then WIDTH=8, STAGES=1. Check against a reference model: 1000 random beats with random stalls give zero mismatches.
